// File: rtl/stack_pkg.sv
// Shared stack command encodings and error codes for the operand stack and its controller.
package stack_pkg;

  typedef enum logic [2:0] {
    NOP     = 3'b000,
    PUSH    = 3'b001,
    POP     = 3'b010,
    REPLACE = 3'b011,
    DUP     = 3'b100,
    SWAP    = 3'b101,
    CLEAR   = 3'b110,
    ILLEGAL = 3'b111
  } op_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UDF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/stack_regfile.sv
// Operand stack storage: two indexed write ports (for SWAP) and two combinational read ports.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    raddr_top,
  input  logic [AW-1:0]    raddr_next,
  output logic [WIDTH-1:0] rd_top,
  output logic [WIDTH-1:0] rd_next
);

  // Rounded up to a power of two so any AW-bit index is in range; extra slots are never written.
  localparam int unsigned NSLOT = 1 << AW;

  logic [WIDTH-1:0] mem [NSLOT];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rd_top  = mem[raddr_top];
  assign rd_next = mem[raddr_next];

endmodule

// File: rtl/stack_engine.sv
// Parametrised operand stack: one command per cycle, legality checks, occupancy count and sticky error latch.
module stack_engine
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    top_idx, next_idx, push_idx;
  logic [WIDTH-1:0] rd_top, rd_next;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic [CW-1:0]    count_next;
  logic             fault, clr;
  logic [1:0]       fault_code;

  assign top_idx  = AW'(count - CW'(1));
  assign next_idx = AW'(count - CW'(2));
  assign push_idx = AW'(count);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign tos   = empty ? '0 : rd_top;
  assign nos   = (count < CW'(2)) ? '0 : rd_next;

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk        (clk),
    .we0        (we0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .we1        (we1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .raddr_top  (top_idx),
    .raddr_next (next_idx),
    .rd_top     (rd_top),
    .rd_next    (rd_next)
  );

  always_comb begin
    we0        = 1'b0;
    we1        = 1'b0;
    waddr0     = top_idx;
    waddr1     = next_idx;
    wdata0     = din;
    wdata1     = rd_top;
    count_next = count;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    clr        = 1'b0;
    case (op_e'(op))
      NOP: ;
      PUSH: begin
        if (full) begin
          fault = 1'b1; fault_code = ERR_OVF;
        end else begin
          we0 = 1'b1; waddr0 = push_idx; count_next = count + CW'(1);
        end
      end
      POP: begin
        if (empty) begin
          fault = 1'b1; fault_code = ERR_UDF;
        end else begin
          count_next = count - CW'(1);
        end
      end
      REPLACE: begin
        if (empty) begin
          fault = 1'b1; fault_code = ERR_UDF;
        end else begin
          we0 = 1'b1;
        end
      end
      // Empty is tested before full so a DUP on an empty stack reports underflow.
      DUP: begin
        if (empty) begin
          fault = 1'b1; fault_code = ERR_UDF;
        end else if (full) begin
          fault = 1'b1; fault_code = ERR_OVF;
        end else begin
          we0 = 1'b1; waddr0 = push_idx; wdata0 = rd_top; count_next = count + CW'(1);
        end
      end
      SWAP: begin
        if (count < CW'(2)) begin
          fault = 1'b1; fault_code = ERR_UDF;
        end else begin
          we0 = 1'b1; wdata0 = rd_next;
          we1 = 1'b1; wdata1 = rd_top;
        end
      end
      CLEAR:   clr = 1'b1;
      ILLEGAL: begin
        fault = 1'b1; fault_code = ERR_ILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (clr) begin
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      count <= count_next;
      if (fault && !err) begin
        err      <= 1'b1;
        err_code <= fault_code;
      end
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: queue-based reference model checked every cycle, plus directed literal checks.
module tb_stack_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       op  = 3'b000;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, err;
  logic [1:0]       err_code;

  int n_tests = 0;
  int n_fail  = 0;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .din      (din),
    .tos      (tos),
    .nos      (nos),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Reference model: the stack as a queue, top at the back.
  logic [WIDTH-1:0] mstk[$];
  logic             merr  = 1'b0;
  logic [1:0]       mcode = 2'b00;

  function automatic void mfault(input logic [1:0] c);
    if (!merr) begin
      merr  = 1'b1;
      mcode = c;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstk.delete();
      merr  = 1'b0;
      mcode = 2'b00;
    end else begin
      int n;
      logic [WIDTH-1:0] t;
      n = mstk.size();
      case (op)
        3'd1: if (n == DEPTH) mfault(2'b01); else mstk.push_back(din);
        3'd2: if (n == 0) mfault(2'b10); else void'(mstk.pop_back());
        3'd3: if (n == 0) mfault(2'b10); else mstk[n-1] = din;
        3'd4: if (n == 0) mfault(2'b10);
              else if (n == DEPTH) mfault(2'b01);
              else mstk.push_back(mstk[n-1]);
        3'd5: if (n < 2) mfault(2'b10);
              else begin
                t = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = t;
              end
        3'd6: begin mstk.delete(); merr = 1'b0; mcode = 2'b00; end
        3'd7: mfault(2'b11);
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    int n;
    n = mstk.size();
    chk("m_count", 32'(count), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full",  32'(full),  32'(n == DEPTH));
    chk("m_tos",   32'(tos),   (n >= 1) ? 32'(mstk[n-1]) : 32'd0);
    chk("m_nos",   32'(nos),   (n >= 2) ? 32'(mstk[n-2]) : 32'd0);
    chk("m_err",   32'(err),   32'(merr));
    chk("m_code",  32'(err_code), 32'(mcode));
  end

  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    #1;
    op  = o;
    din = d;
    @(posedge clk);
    #1;
    op = 3'd0;
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_tos",   32'(tos), 0);
    chk("rst_nos",   32'(nos), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_code",  32'(err_code), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    do_op(3'd1, 8'h11);
    do_op(3'd1, 8'h22);
    do_op(3'd1, 8'h33);
    chk("push3_count", 32'(count), 3);
    chk("push3_tos", 32'(tos), 32'h33);
    chk("push3_nos", 32'(nos), 32'h22);
    chk("push3_err", 32'(err), 0);

    do_op(3'd5, 8'h00);
    chk("swap_tos", 32'(tos), 32'h22);
    chk("swap_nos", 32'(nos), 32'h33);
    do_op(3'd2, 8'h00);
    chk("pop_count", 32'(count), 2);
    chk("pop_tos", 32'(tos), 32'h33);
    chk("pop_nos", 32'(nos), 32'h11);

    do_op(3'd4, 8'h00);
    chk("dup_count", 32'(count), 3);
    chk("dup_tos", 32'(tos), 32'h33);
    do_op(3'd3, 8'h5A);
    chk("repl_count", 32'(count), 3);
    chk("repl_tos", 32'(tos), 32'h5A);
    chk("repl_nos", 32'(nos), 32'h33);

    for (int i = 0; i < 5; i++) do_op(3'd1, 8'(8'h40 + i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    do_op(3'd1, 8'hFF);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_code", 32'(err_code), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_tos", 32'(tos), 32'h44);
    do_op(3'd2, 8'h00);
    chk("ovfpop_count", 32'(count), 7);
    chk("ovfpop_code", 32'(err_code), 1);

    do_op(3'd6, 8'h00);
    chk("clr_err", 32'(err), 0);
    chk("clr_count", 32'(count), 0);
    do_op(3'd2, 8'h00);
    chk("udf_code", 32'(err_code), 2);
    do_op(3'd1, 8'h01);
    do_op(3'd5, 8'h00);
    chk("swap1_code", 32'(err_code), 2);
    chk("swap1_count", 32'(count), 1);
    do_op(3'd7, 8'h00);
    chk("ill_keep_code", 32'(err_code), 2);
    chk("ill_keep_err", 32'(err), 1);
    do_op(3'd6, 8'h00);
    chk("clr2_err", 32'(err), 0);
    chk("clr2_count", 32'(count), 0);
    do_op(3'd6, 8'h00);
    chk("clr_empty_err", 32'(err), 0);

    do_op(3'd4, 8'h00);
    chk("dup_empty_code", 32'(err_code), 2);
    do_op(3'd6, 8'h00);

    for (int i = 0; i < 5; i++) do_op(3'd1, 8'(8'hA0 + i));
    do_op(3'd7, 8'h00);
    chk("ill_code", 32'(err_code), 3);
    chk("ill_count", 32'(count), 5);
    #1 rst = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_tos", 32'(tos), 0);
    chk("async_err", 32'(err), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    do_op(3'd1, 8'h77);
    chk("rel_count", 32'(count), 1);
    chk("rel_tos", 32'(tos), 32'h77);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] o;
      r = int'($urandom_range(0, 99));
      if (r < 35)      o = 3'd1;
      else if (r < 60) o = 3'd2;
      else if (r < 68) o = 3'd3;
      else if (r < 76) o = 3'd4;
      else if (r < 84) o = 3'd5;
      else if (r < 89) o = 3'd0;
      else if (r < 95) o = 3'd7;
      else             o = 3'd6;
      @(negedge clk);
      #1;
      op  = o;
      din = 8'($urandom);
      if (i == 1500) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    #1 op = 3'd0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
